// File: rtl/cpu_pkg.sv
// Shared register-file geometry and write-back arbiter state encoding.
package cpu_pkg;
   localparam int AW      = 5;
   localparam int DW      = 32;
   localparam int REG_NUM = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FORCE = 2'd2
   } wb_state_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bit per register for long-latency results, with three hazard
// query ports that bypass a result being committed in the current cycle.
module wb_scoreboard #(
   parameter int AW      = cpu_pkg::AW,
   parameter int REG_NUM = cpu_pkg::REG_NUM
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  logic [AW-1:0]       set_addr,
   input  logic                clr_en,
   input  logic [AW-1:0]       clr_addr,
   input  logic [2:0][AW-1:0]  q_addr,
   output logic [2:0]          haz
);
   logic [REG_NUM-1:1] pending_reg;
   logic [REG_NUM-1:0] pending_vec;

   assign pending_vec = {pending_reg, 1'b0};

   genvar gi;
   generate
      for (gi = 1; gi < REG_NUM; gi++) begin : g_bit
         // A newer issue to the same register outranks the older commit.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               pending_reg[gi] <= 1'b0;
            else if (set_en && set_addr == AW'(gi))
               pending_reg[gi] <= 1'b1;
            else if (clr_en && clr_addr == AW'(gi))
               pending_reg[gi] <= 1'b0;
         end
      end

      for (gi = 0; gi < 3; gi++) begin : g_query
         assign haz[gi] = pending_vec[q_addr[gi]] && (q_addr[gi] != '0) &&
                          !(clr_en && clr_addr == q_addr[gi]);
      end
   endgenerate
endmodule

// File: rtl/regs_wb_arbiter.sv
// Shares the register-file write port between the pipeline WB stage and a
// multi-cycle mul/div unit, with bounded starvation of the buffered M result.
module regs_wb_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int AW         = cpu_pkg::AW,
   parameter int DW         = cpu_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p_we,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_data,
   input  logic          m_valid,
   input  logic [AW-1:0] m_addr,
   input  logic [DW-1:0] m_data,
   output logic          m_ready,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_addr,
   input  logic [AW-1:0] q_rs1,
   input  logic [AW-1:0] q_rs2,
   input  logic [AW-1:0] q_rd,
   output logic          haz_rs1,
   output logic          haz_rs2,
   output logic          haz_rd,
   output logic          p_stall,
   output logic          rf_we,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_data
);
   import cpu_pkg::*;

   wb_state_t     state_reg;
   logic          m_ready_reg;
   logic [3:0]    cnt_reg;
   logic [AW-1:0] baddr_reg;
   logic [DW-1:0] bdata_reg;
   logic [AW-1:0] last_addr_reg;
   logic [DW-1:0] last_data_reg;
   logic          pe;
   logic          commit;
   logic [2:0]    haz;

   assign p_stall = (state_reg == FORCE);
   assign m_ready = m_ready_reg;
   assign pe      = p_we && (p_addr != '0) && !p_stall && !rst;
   assign commit  = (state_reg == FORCE) || ((state_reg == HOLD) && !pe);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         m_ready_reg <= 1'b1;
         cnt_reg     <= '0;
         baddr_reg   <= '0;
         bdata_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               // Results for x0 complete the handshake and are discarded.
               if (m_valid && m_ready_reg && m_addr != '0) begin
                  baddr_reg   <= m_addr;
                  bdata_reg   <= m_data;
                  state_reg   <= HOLD;
                  m_ready_reg <= 1'b0;
               end
            end
            HOLD: begin
               if (pe) begin
                  cnt_reg <= cnt_reg + 4'd1;
                  if (cnt_reg + 4'd1 == 4'(STARVE_MAX))
                     state_reg <= FORCE;
               end else begin
                  cnt_reg     <= '0;
                  state_reg   <= IDLE;
                  m_ready_reg <= 1'b1;
               end
            end
            default: begin
               cnt_reg     <= '0;
               state_reg   <= IDLE;
               m_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   // Idle cycles repeat the last written address/data so the port never floats.
   always_comb begin
      rf_we   = 1'b0;
      rf_addr = last_addr_reg;
      rf_data = last_data_reg;
      if (pe) begin
         rf_we   = 1'b1;
         rf_addr = p_addr;
         rf_data = p_data;
      end else if (commit) begin
         rf_we   = 1'b1;
         rf_addr = baddr_reg;
         rf_data = bdata_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_addr_reg <= '0;
         last_data_reg <= '0;
      end else if (rf_we) begin
         last_addr_reg <= rf_addr;
         last_data_reg <= rf_data;
      end
   end

   wb_scoreboard #(.AW(AW), .REG_NUM(REG_NUM)) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (iss_valid && iss_addr != '0),
      .set_addr (iss_addr),
      .clr_en   (commit),
      .clr_addr (baddr_reg),
      .q_addr   ({q_rd, q_rs2, q_rs1}),
      .haz      (haz)
   );

   assign haz_rs1 = haz[0];
   assign haz_rs2 = haz[1];
   assign haz_rd  = haz[2];
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench: directed phases push expected register-file writes to
// a queue, and a falling-edge monitor pops and compares each DUT write.
module tb_regs_wb_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          p_we;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_data;
   logic          m_valid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic          iss_valid;
   logic [AW-1:0] iss_addr;
   logic [AW-1:0] q_rs1, q_rs2, q_rd;
   logic          haz_rs1, haz_rs2, haz_rd;
   logic          p_stall;
   logic          rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   always #5 clk = ~clk;

   regs_wb_arbiter #(.STARVE_MAX(4), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .p_we(p_we), .p_addr(p_addr), .p_data(p_data),
      .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
      .iss_valid(iss_valid), .iss_addr(iss_addr),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
      .haz_rs1(haz_rs1), .haz_rs2(haz_rs2), .haz_rd(haz_rd),
      .p_stall(p_stall),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (!rst && rf_we) begin
         if (exp_q.size() == 0) begin
            check("unexp_wr", {63'd0, rf_we}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", {59'd0, rf_addr}, {59'd0, e.a});
            check("wr_data", {32'd0, rf_data}, {32'd0, e.d});
            $display("write x%0d = 0x%0h", rf_addr, rf_data);
         end
      end
   end

   initial begin
      int idx;
      rst = 1'b1; p_we = 0; p_addr = 0; p_data = 0;
      m_valid = 0; m_addr = 0; m_data = 0; iss_valid = 0; iss_addr = 0;
      q_rs1 = 0; q_rs2 = 0; q_rd = 0;

      // Reset state
      step(); step(); samp();
      check("rst_m_ready", {63'd0, m_ready}, 64'd1);
      check("rst_p_stall", {63'd0, p_stall}, 64'd0);
      check("rst_rf_we", {63'd0, rf_we}, 64'd0);
      check("rst_rf_addr", {59'd0, rf_addr}, 64'd0);
      check("rst_rf_data", {32'd0, rf_data}, 64'd0);
      check("rst_haz", {61'd0, haz_rs1, haz_rs2, haz_rd}, 64'd0);
      step(); rst = 1'b0;

      // Idle-port drain of x7
      iss_valid = 1; iss_addr = 7; q_rd = 7;
      step(); iss_valid = 0;
      m_valid = 1; m_addr = 7; m_data = 32'h1234;
      exp_q.push_back('{a: 5'd7, d: 32'h1234});
      samp();
      check("drain_haz_pend", {63'd0, haz_rd}, 64'd1);
      check("drain_m_ready", {63'd0, m_ready}, 64'd1);
      step(); m_valid = 0;
      samp();
      check("drain_bypass", {63'd0, haz_rd}, 64'd0);
      check("drain_busy", {63'd0, m_ready}, 64'd0);
      step(); samp();
      check("drain_cleared", {63'd0, haz_rd}, 64'd0);
      check("drain_ready", {63'd0, m_ready}, 64'd1);
      check("drain_hold_addr", {59'd0, rf_addr}, 64'd7);
      check("drain_hold_data", {32'd0, rf_data}, 64'h1234);

      // Starvation: buffer x9 while P writes x3 every cycle
      step(); iss_valid = 1; iss_addr = 9;
      step(); iss_valid = 0;
      m_valid = 1; m_addr = 9; m_data = 32'h99;
      step(); m_valid = 0;
      for (int k = 0; k < 4; k++) begin
         p_we = 1; p_addr = 3; p_data = 32'h300 + k;
         exp_q.push_back('{a: 5'd3, d: 32'h300 + k});
         samp();
         check("starve_no_stall", {63'd0, p_stall}, 64'd0);
         step();
      end
      p_data = 32'h304;
      exp_q.push_back('{a: 5'd9, d: 32'h99});
      samp();
      check("starve_stall", {63'd0, p_stall}, 64'd1);
      check("starve_force_addr", {59'd0, rf_addr}, 64'd9);
      step();
      exp_q.push_back('{a: 5'd3, d: 32'h304});
      samp();
      check("starve_resume", {63'd0, p_stall}, 64'd0);
      check("starve_m_ready", {63'd0, m_ready}, 64'd1);
      step(); p_we = 0;

      // x0 handling
      p_we = 1; p_addr = 0; p_data = 32'hdead;
      samp();
      check("x0_p_we", {63'd0, rf_we}, 64'd0);
      step(); p_we = 0;
      m_valid = 1; m_addr = 0; m_data = 32'hbeef;
      samp();
      check("x0_m_ready", {63'd0, m_ready}, 64'd1);
      step(); m_valid = 0;
      samp();
      check("x0_still_idle", {63'd0, m_ready}, 64'd1);
      check("x0_m_no_wr", {63'd0, rf_we}, 64'd0);

      // Set/clear collision on x12
      step(); iss_valid = 1; iss_addr = 12; q_rs1 = 12;
      step(); iss_valid = 0;
      m_valid = 1; m_addr = 12; m_data = 32'hc0;
      exp_q.push_back('{a: 5'd12, d: 32'hc0});
      step(); m_valid = 0; iss_valid = 1; iss_addr = 12;
      samp();
      check("coll_bypass", {63'd0, haz_rs1}, 64'd0);
      step(); iss_valid = 0;
      samp();
      check("coll_set_wins", {63'd0, haz_rs1}, 64'd1);
      step(); m_valid = 1; m_addr = 12; m_data = 32'hc1;
      exp_q.push_back('{a: 5'd12, d: 32'hc1});
      step(); m_valid = 0;
      step(); samp();
      check("coll_cleared", {63'd0, haz_rs1}, 64'd0);

      // Back-to-back M results, P idle
      for (int k = 0; k < 3; k++) begin
         step(); iss_valid = 1; iss_addr = AW'(20 + k);
      end
      step(); iss_valid = 0; q_rs2 = 21;
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         m_valid = (idx < 3);
         m_addr = AW'(20 + idx);
         m_data = 32'ha000 + idx;
         if (k % 2 == 0) exp_q.push_back('{a: AW'(20 + idx), d: 32'ha000 + idx});
         samp();
         check("b2b_m_ready", {63'd0, m_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
         check("b2b_rf_we", {63'd0, rf_we}, (k % 2 == 1) ? 64'd1 : 64'd0);
         if (k % 2 == 0) idx++;
         step();
      end
      m_valid = 0;
      samp();
      check("b2b_haz_clear", {63'd0, haz_rs2}, 64'd0);

      // Asynchronous reset while HOLD with pending x5
      step(); iss_valid = 1; iss_addr = 5; q_rd = 5;
      step(); iss_valid = 0;
      m_valid = 1; m_addr = 5; m_data = 32'h55;
      step(); m_valid = 0;
      p_we = 1; p_addr = 4; p_data = 32'h44;
      exp_q.push_back('{a: 5'd4, d: 32'h44});
      samp();
      check("hold_haz_pend", {63'd0, haz_rd}, 64'd1);
      check("hold_m_busy", {63'd0, m_ready}, 64'd0);
      #2 rst = 1'b1;
      #1;
      check("arst_rf_we", {63'd0, rf_we}, 64'd0);
      check("arst_p_stall", {63'd0, p_stall}, 64'd0);
      check("arst_haz", {61'd0, haz_rs1, haz_rs2, haz_rd}, 64'd0);
      check("arst_m_ready", {63'd0, m_ready}, 64'd1);
      step(); rst = 1'b0; p_we = 0;
      step(); samp();
      check("post_rst_no_wr", {63'd0, rf_we}, 64'd0);
      check("post_rst_haz", {63'd0, haz_rd}, 64'd0);
      step();

      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Write-back arbiter and scoreboard for the 32x32 register file's single write port (write enable, write address, write data; write on falling clk edge; x0 hard-wired zero).
- Shares the port between the in-order pipeline WB stage (source P, priority) and a multi-cycle mul/div unit (source M, valid/ready).
- Tracks registers with an outstanding M result so the ID stage can stall on RAW/WAW hazards.
- Bounds M starvation by briefly stalling the pipeline.

Parameters:
- STARVE_MAX, 4: consecutive cycles a buffered M result may be blocked by P before the pipeline is force-stalled (1..15).
- AW, 5: register address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, rising-edge logic.
- rst  in  1  asynchronous active-high reset.
- p_we  in  1  pipeline WB write request.
- p_addr  in  AW  pipeline WB destination.
- p_data  in  DW  pipeline WB data.
- m_valid  in  1  M result valid.
- m_addr  in  AW  M destination.
- m_data  in  DW  M result.
- m_ready  out  1  M result accepted this cycle when m_valid & m_ready.
- iss_valid  in  1  ID issues a long-latency op this cycle.
- iss_addr  in  AW  its destination.
- q_rs1, q_rs2, q_rd  in  AW  ID hazard query addresses.
- haz_rs1, haz_rs2, haz_rd  out  1  queried register has a pending M write.
- p_stall  out  1  pipeline must freeze; WB holds its request.
- rf_we  out  1  register-file write enable (L_S).
- rf_addr  out  AW  register-file write address.
- rf_data  out  DW  register-file write data.

Behaviour:
- Reset values:
  - state IDLE, buffer invalid, starve counter 0, all pending bits 0.
  - m_ready=1, p_stall=0, rf_we=0, rf_addr=0, rf_data=0, haz_*=0.
- Effective P request: pe = p_we & (p_addr!=0) & ~p_stall. An x0 write never reaches rf_we.
- One-entry buffer {baddr, bdata} holds an accepted M result. m_ready = (state==IDLE), driven registered from state.
- FSM:
  - IDLE: on m_valid & m_ready with m_addr!=0, capture into buffer and go to HOLD.
    - An accepted m_addr==0 result is dropped; stay IDLE.
  - HOLD, ~pe: write the buffer this cycle, clear its pending bit at the clock edge, counter<=0, go to IDLE.
  - HOLD, pe: P writes. Counter<=counter+1; if counter+1==STARVE_MAX, go to FORCE.
  - FORCE: p_stall=1 (decoded from state). Write the buffer, clear its pending bit, counter<=0, go to IDLE. p_we is ignored this cycle; the pipeline re-presents it next cycle.
- Write-port mux is combinational, same cycle:
  - pe=1 and state!=FORCE: rf_*=P.
  - Otherwise, state in {HOLD, FORCE}: rf_*=buffer.
  - Otherwise rf_we=0 and rf_addr/rf_data hold their last value. rf_addr/rf_data are don't-care when rf_we=0, but must be deterministic.
- Worst-case M latency from acceptance to write: STARVE_MAX+1 cycles. M throughput: one result per 2 cycles minimum.
- Scoreboard, 31 pending bits (x0 has none):
  - iss_valid & iss_addr!=0 sets pending[iss_addr].
  - Buffer commit clears pending[baddr].
  - Set and clear of the same address in the same cycle: set wins (newer op outstanding).
  - haz_x = pending[q_x] & (q_x!=0), combinational.
  - Same-cycle bypass: while the buffer is committing to q_x this cycle, haz_x=0. The regfile writes on the falling edge, so the value is readable in the second half-cycle.
- Usage contract: ID must not issue a P-writer or long-latency op whose rd has haz_rd=1. The arbiter does not reorder same-address writes.
- Reset asserted mid-operation: buffer contents lost, pending bits cleared, any FORCE stall released immediately (async).

Decomposition:
- Shared package (cpu_pkg): AW, DW, REG_NUM=32, state encoding (IDLE=2'd0, HOLD=2'd1, FORCE=2'd2).
- One natural sub-module: wb_scoreboard (pending bit-vector, set/clear, three query decoders with bypass).
- FSM, buffer and mux stay in the top.

Test Plan:
- Reset: assert rst mid-HOLD with pending[5]=1 -> rf_we=0, p_stall=0, haz_*=0, m_ready=1 asynchronously.
- Idle-port drain: iss x7; next cycle m_valid, m_addr=7, m_data=0x1234, p_we=0 -> accepted. Next cycle rf_we=1, rf_addr=7, rf_data=0x1234, haz_rd(q_rd=7)=0 in that cycle, pending[7] cleared after the edge.
- Starvation, STARVE_MAX=4: buffer x9, p_we=1 to x3 for 4 cycles -> 4 P writes, then p_stall=1 for 1 cycle with rf_addr=9, then P resumes; m_ready returns 1.
- x0 handling: p_we=1, p_addr=0 -> rf_we=0. M result to x0 -> m_ready handshake completes, no write, state stays IDLE.
- Set/clear collision: buffer commits x12 while iss_valid, iss_addr=12 -> pending[12] remains 1, haz_rs1(q_rs1=12)=1 next cycle.
- Back-to-back M: m_valid held with 3 results, P idle -> writes on cycles 2, 4, 6 after the first acceptance; m_ready toggles 1,0,1,0.
